// File: rtl/prco_constants.sv
// Shared owner encodings and read-tag layout for the PRCO local-memory arbiter.
// No logic; types and constants only.
// Imported by the arbiter top and the tag pipeline.
package prco_constants;

    localparam logic [1:0] OWN_FETCH = 2'd0;
    localparam logic [1:0] OWN_DATA  = 2'd1;
    localparam logic [1:0] OWN_DBG   = 2'd2;

    // One in-flight read: live marks a return that must still be delivered.
    typedef struct packed {
        logic       live;
        logic [1:0] owner;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Drop the live bit of a fetch-owned tag while a branch flush is active.
    function automatic tag_t kill_fetch(input tag_t t, input logic flush);
        tag_t r;
        r = t;
        if (flush && (t.owner == OWN_FETCH)) begin
            r.live = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/prco_mem_tagpipe.sv
// Shift register of read tags, DEPTH stages, with flush-by-owner clear of fetch tags.
// Latency: a tag pushed in cycle N is presented at q_tag in cycle N+DEPTH.
// No backpressure: advances every cycle; flush clears fetch tags on entry and in flight.
module prco_mem_tagpipe
    import prco_constants::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_flush,
    input  tag_t i_tag,
    output tag_t q_tag,
    output logic q_busy
);

    tag_t stages [DEPTH];

    // Advance the pipeline each cycle, killing fetch returns during a flush.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= kill_fetch(i_tag, i_flush);
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= kill_fetch(stages[i-1], i_flush);
            end
        end
    end

    // Busy whenever any stage still carries a deliverable return.
    always_comb begin
        q_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            q_busy = q_busy | stages[i].live;
        end
    end

    assign q_tag = stages[DEPTH-1];

endmodule

// File: rtl/prco_mem_arb.sv
// Single-port lmem arbiter: debug > data > fetch, with fetch forced after STARVE_MAX denials.
// Latency: grant same cycle, mem lines registered next cycle, read valid at N+1+RD_LAT.
// Backpressure: requesters hold until their combinational gnt; at most one grant per cycle.
module prco_mem_arb
    import prco_constants::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,   // legal range 1..3
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              q_f_gnt,
    output logic              q_f_valid,
    output logic [DATA_W-1:0] q_f_data,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              q_d_gnt,
    output logic              q_d_valid,
    output logic [DATA_W-1:0] q_d_data,
    input  logic              i_g_req,
    input  logic              i_g_we,
    input  logic [ADDR_W-1:0] i_g_addr,
    input  logic [DATA_W-1:0] i_g_wdata,
    output logic              q_g_gnt,
    output logic              q_g_valid,
    output logic [DATA_W-1:0] q_g_data,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic              q_mem_we,
    output logic [DATA_W-1:0] q_mem_dina,
    input  logic [DATA_W-1:0] i_mem_douta,
    output logic              q_busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt;
    logic              starve_force;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_owner;
    tag_t              new_tag;
    tag_t              ret_tag;
    logic              ret_fetch;
    logic              ret_data;
    logic              ret_dbg;

    assign starve_force = i_f_req && (starve_cnt == CNT_MAX);

    // Fixed priority arbitration with the starvation override; nothing granted in reset.
    always_comb begin
        q_f_gnt = 1'b0;
        q_d_gnt = 1'b0;
        q_g_gnt = 1'b0;
        if (!i_reset) begin
            if (starve_force) begin
                q_f_gnt = 1'b1;
            end else if (i_g_req) begin
                q_g_gnt = 1'b1;
            end else if (i_d_req) begin
                q_d_gnt = 1'b1;
            end else if (i_f_req) begin
                q_f_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = q_f_gnt | q_d_gnt | q_g_gnt;

    // Steer the winner's request onto the memory lines; idle holds address and data.
    always_comb begin
        sel_addr  = q_mem_addr;
        sel_we    = 1'b0;
        sel_wdata = q_mem_dina;
        sel_owner = OWN_FETCH;
        if (q_f_gnt) begin
            sel_addr  = i_f_addr;
            sel_owner = OWN_FETCH;
        end else if (q_g_gnt) begin
            sel_addr  = i_g_addr;
            sel_we    = i_g_we;
            sel_wdata = i_g_wdata;
            sel_owner = OWN_DBG;
        end else if (q_d_gnt) begin
            sel_addr  = i_d_addr;
            sel_we    = i_d_we;
            sel_wdata = i_d_wdata;
            sel_owner = OWN_DATA;
        end
    end

    // Register the granted access onto the lmem port.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_mem_addr <= '0;
            q_mem_we   <= 1'b0;
            q_mem_dina <= '0;
        end else begin
            q_mem_addr <= sel_addr;
            q_mem_we   <= sel_we;
            q_mem_dina <= sel_wdata;
        end
    end

    // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt <= '0;
        end else if (i_f_req && !q_f_gnt) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Only reads produce a return; writes complete on grant.
    always_comb begin
        new_tag       = '0;
        new_tag.live  = any_gnt && !sel_we;
        new_tag.owner = sel_owner;
    end

    prco_mem_tagpipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tagpipe (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_tag   (new_tag),
        .q_tag   (ret_tag),
        .q_busy  (q_busy)
    );

    // Route the returning word to its owner; a flush in the return cycle also kills fetch.
    always_comb begin
        ret_fetch = !i_reset && ret_tag.live && (ret_tag.owner == OWN_FETCH) && !i_flush;
        ret_data  = !i_reset && ret_tag.live && (ret_tag.owner == OWN_DATA);
        ret_dbg   = !i_reset && ret_tag.live && (ret_tag.owner == OWN_DBG);
    end

    assign q_f_valid = ret_fetch;
    assign q_d_valid = ret_data;
    assign q_g_valid = ret_dbg;
    assign q_f_data  = ret_fetch ? i_mem_douta : '0;
    assign q_d_data  = ret_data  ? i_mem_douta : '0;
    assign q_g_data  = ret_dbg   ? i_mem_douta : '0;

endmodule

// File: doc/prco_mem_arb.md
Name: prco_mem_arb

Overview:
Single-port local-memory arbiter for the PRCO core. It shares one synchronous lmem port between three requesters: instruction fetch, ALU load/store, and the debug/loader port. It grants one access per cycle, drives the memory address/write lines from registers, and routes read data back to the owning requester with a valid pulse. Branch flushes discard in-flight fetch reads.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
RD_LAT, 1, lmem read latency in cycles after address is registered; legal values 1..3
STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_flush  in  1  branch flush; kills in-flight fetch reads
i_f_req  in  1  fetch request (read only)
i_f_addr  in  ADDR_W  fetch address
q_f_gnt  out  1  fetch accepted this cycle
q_f_valid  out  1  fetch read data valid
q_f_data  out  DATA_W  fetch read data
i_d_req  in  1  ALU load/store request
i_d_we  in  1  1 = store
i_d_addr  in  ADDR_W  ALU address
i_d_wdata  in  DATA_W  store data
q_d_gnt  out  1  data accepted
q_d_valid  out  1  load data valid
q_d_data  out  DATA_W  load data
i_g_req  in  1  debug request
i_g_we  in  1  debug write
i_g_addr  in  ADDR_W  debug address
i_g_wdata  in  DATA_W  debug write data
q_g_gnt  out  1  debug accepted
q_g_valid  out  1  debug read valid
q_g_data  out  DATA_W  debug read data
q_mem_addr  out  ADDR_W  lmem address (registered)
q_mem_we  out  1  lmem write enable (registered)
q_mem_dina  out  DATA_W  lmem write data (registered)
i_mem_douta  in  DATA_W  lmem read data
q_busy  out  1  any read in flight

Behaviour:
- Reset: i_reset is asynchronous, active-high; clock is i_clk. On reset, all outputs and q_mem_* are 0, the tag pipeline is cleared, and the starvation counter is 0. Reset mid-transfer drops all returns; no valid is asserted afterwards for pre-reset requests.
- Requester rule: hold req/addr/we/wdata stable until gnt. gnt is combinational in the same cycle N.
- Priority: debug > data > fetch. Exception: when starve_cnt == STARVE_MAX and i_f_req=1, fetch wins over all others.
- starve_cnt behaviour:
  - increments (saturating) each cycle i_f_req=1 and q_f_gnt=0;
  - clears on q_f_gnt or when i_f_req=0.
- Exactly one gnt is high per cycle; with no requests, all gnts are 0.
- The winner's addr/we/wdata are registered into q_mem_* at the end of cycle N. In idle cycles, q_mem_we=0 and q_mem_addr holds its value.
- Writes: complete on grant; no valid pulse.
- Reads: a tag {live, owner[1:0]} enters a shift pipeline of depth RD_LAT+1.
  - In cycle N+1+RD_LAT, the matching q_x_valid pulses for 1 cycle.
  - q_x_data = i_mem_douta (combinational passthrough); q_x_data is don't-care when valid=0.
- Throughput: one access per cycle; back-to-back reads return in order, one per cycle.
- Flush: i_flush=1 clears live on every fetch-owned tag in the pipeline and on a fetch grant issued in the same cycle. q_f_valid is never asserted for those. Data/debug tags are unaffected.
- A simultaneous flush and fetch grant still registers the address, but the return is suppressed.
- q_busy = OR of live bits.
- Address/data widths pass through unchanged; no wrap logic, since the address is used as given.

Decomposition:
- Shared package prco_constants: owner encoding OWN_FETCH=0, OWN_DATA=1, OWN_DBG=2, and the tag struct width.
- One natural sub-module, prco_mem_tagpipe: a parameterised RD_LAT+1 shift register of tags with a flush-by-owner clear. The arbiter and starvation logic stay in the top module.

Test Plan:
- Fetch only, addr 0x0010, memory holds 0xBEEF (RD_LAT=1) -> q_f_gnt in cycle 0, q_mem_addr=0x0010 in cycle 1, q_f_valid with data 0xBEEF in cycle 2.
- Simultaneous data load 0x0020 and fetch 0x0011 -> q_d_gnt first, q_f_gnt next cycle; returns in order, data then fetch, each exactly 1-cycle pulses.
- Continuous data requests plus fetch held (STARVE_MAX=4) -> fetch denied 4 cycles and granted on the 5th, with data denied that cycle.
- Debug write 0x1234 to 0x0005, then a data load of 0x0005 -> q_mem_we=1 for one cycle; load returns 0x1234; no q_g_valid for the write.
- Two fetch reads in flight, then i_flush -> no q_f_valid for either; a data load issued alongside still returns its valid; q_busy falls afterwards.
- i_reset asserted with reads in flight -> all outputs 0 immediately; no valid pulses after release; the first post-reset fetch behaves as in the first scenario.
